bht_access_scheduler: RTL and testbench
=======================================

// Module: bht_access_scheduler
// PURPOSE
//  Sequences the shared branch history table (BHT): one predict or one update command per cycle.
//  Predict and update are never asserted together on the BHT.
//  Fetch-side predict requests and resolve-side update requests are arbitrated here.
//  Updates are buffered in an in-order FIFO and issued in arrival order.
//  A starvation counter guarantees update forward progress under continuous predict traffic.
// PARAMETERS
//  ADDR_W      11  branch address width; matches the BHT branch_addr port
//  UPD_DEPTH   4   update FIFO entries (power of two, >=2)
//  STARVE_MAX  3   consecutive predicts issued while FIFO is non-empty before an update is forced
// PORTS
//  clock        in   1                       rising-edge clock
//  reset        in   1                       asynchronous, active-high reset
//  pred_req     in   1                       fetch requests a prediction
//  pred_addr    in   ADDR_W                  branch address to predict
//  pred_ready   out  1                       predict accepted this cycle when pred_req&&pred_ready
//  pred_valid   out  1                       prediction response valid (one-cycle pulse)
//  pred_taken   out  1                       predicted direction, meaningful only when pred_valid
//  upd_valid    in   1                       resolve stage offers a branch outcome
//  upd_addr     in   ADDR_W                  resolved branch address
//  upd_result   in   1                       actual outcome (1 = taken)
//  upd_ready    out  1                       FIFO not full; enqueue when upd_valid&&upd_ready
//  upd_count    out  $clog2(UPD_DEPTH+1)     entries currently queued
//  bht_addr     out  ADDR_W                  to BHT branch_addr (registered)
//  bht_predict  out  1                       to BHT predict (registered)
//  bht_update   out  1                       to BHT update (registered)
//  bht_result   out  1                       to BHT branch_result (registered)
//  bht_prediction in 1                       from BHT prediction
// BEHAVIOUR
//  Reset:
//   - While reset is high, all registered outputs are 0, the FIFO is empty, starve_cnt=0 and state=IDLE.
//   - pred_ready and upd_ready are forced to 0 while reset is high.
//   - Reset asserted mid-operation drops any in-flight command and response. No pred_valid is produced for it.
//  Ready signals (combinational):
//   - pred_ready = !reset && !(upd_count!=0 && starve_cnt==STARVE_MAX)
//   - upd_ready  = !reset && (upd_count!=UPD_DEPTH)
//   - upd_ready does not consider a same-cycle dequeue, so a full FIFO never accepts.
//  Arbitration, evaluated every edge, defines the next state:
//   - FORCE: FIFO non-empty and starve_cnt==STARVE_MAX -> state=ISSUE_UPD, pop head.
//   - PRED: else if pred_req -> state=ISSUE_PRED with bht_addr=pred_addr.
//     If FIFO non-empty, starve_cnt = min(starve_cnt+1, STARVE_MAX).
//   - UPD: else if FIFO non-empty -> state=ISSUE_UPD, pop head.
//   - IDLE: else state=IDLE with bht_predict=bht_update=0. bht_addr holds its last value.
//   - Any ISSUE_UPD clears starve_cnt to 0.
//   - In ISSUE_PRED: bht_predict=1, bht_update=0.
//   - In ISSUE_UPD: bht_update=1, bht_predict=0, bht_addr/bht_result taken from the popped entry.
//  FIFO:
//   - Enqueue and dequeue on the same edge are both honoured; upd_count is unchanged.
//   - An update enqueued while the FIFO is empty cannot issue before the following edge (no bypass).
//   - Pointers wrap modulo UPD_DEPTH.
//  Predict latency is 2 cycles:
//   - Request accepted at edge E0.
//   - bht_predict=1 during cycle E0..E1; the BHT samples at E1.
//   - pred_valid=1 during cycle E1..E2, with pred_taken=bht_prediction passed through combinationally.
//   - Back-to-back predicts give back-to-back pred_valid pulses.
//  Ordering:
//   - No forwarding between a queued update and a predict to the same address. A predict may see stale state.
//  Invariant: bht_predict && bht_update is never 1.
// TESTING
//  T1 reset:
//   - Assert reset mid-stream.
//   - All bht_* and pred_valid drop to 0 and both readies are 0.
//   - After release: upd_count=0, pred_ready=1, upd_ready=1.
//  T2 predict latency:
//   - Single pred_req with pred_addr=0x123 at E0.
//   - bht_predict=1 and bht_addr=0x123 after E0.
//   - pred_valid=1 after E1, and pred_taken equals bht_prediction.
//  T3 starvation:
//   - Enqueue one update (0x040, taken), then hold pred_req high.
//   - Exactly 3 predicts issue, then one ISSUE_UPD with bht_result=1.
//   - pred_ready=0 for exactly that cycle.
//  T4 FIFO full:
//   - With pred_req held high and 4 updates queued, present a 5th update.
//   - upd_ready=0, upd_count stays 4, and the 5th update is not lost (the source holds it).
//   - Order of ISSUE_UPD addresses equals enqueue order.
//  T5 simultaneous enqueue/dequeue:
//   - Full FIFO, pred_req=0, upd_valid=1.
//   - First edge: pop only, count 4->3.
//   - Next edge: push+pop, count stays 3.
//   - Pointer wrap is exercised over 10 updates with addresses 0..9 issued in order.
//  T6 mutual exclusion:
//   - Random pred_req/upd_valid traffic for 10k cycles.
//   - Assertion: never bht_predict&&bht_update.
//   - Every accepted predict yields exactly one pred_valid.

Source files
------------

// File: rtl/bht_access_scheduler.sv
// bht_access_scheduler
//   Arbitrates fetch-side predict requests and resolve-side update requests onto
//   the shared branch history table, issuing at most one command per cycle.
//   Updates are queued in an in-order FIFO. A starvation counter forces an
//   update after STARVE_MAX predicts have issued while updates were waiting.
//
// Ports
//   clock, reset                    clock and asynchronous active-high reset
//   pred_req/pred_addr/pred_ready   predict request handshake from fetch
//   pred_valid/pred_taken           prediction response, two cycles after accept
//   upd_valid/upd_addr/upd_result   update offer from resolve
//   upd_ready/upd_count             FIFO has space / FIFO occupancy
//   bht_addr/bht_predict/
//   bht_update/bht_result           registered command to the BHT
//   bht_prediction                  prediction read back from the BHT
module bht_access_scheduler #(
    parameter int ADDR_W     = 11,
    parameter int UPD_DEPTH  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           pred_req,
    input  logic [ADDR_W-1:0]              pred_addr,
    output logic                           pred_ready,
    output logic                           pred_valid,
    output logic                           pred_taken,
    input  logic                           upd_valid,
    input  logic [ADDR_W-1:0]              upd_addr,
    input  logic                           upd_result,
    output logic                           upd_ready,
    output logic [$clog2(UPD_DEPTH+1)-1:0] upd_count,
    output logic [ADDR_W-1:0]              bht_addr,
    output logic                           bht_predict,
    output logic                           bht_update,
    output logic                           bht_result,
    input  logic                           bht_prediction
);

    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int CNT_W = $clog2(UPD_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE_PRED = 2'd1,
        ISSUE_UPD  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fifo_addr   [UPD_DEPTH];
    logic              fifo_result [UPD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [STV_W-1:0]  starve_cnt;

    logic fifo_nonempty;
    logic force_upd;
    logic take_pred;
    logic push;
    logic pop;

    assign fifo_nonempty = (upd_count != '0);
    assign force_upd     = fifo_nonempty && (starve_cnt == STV_W'(STARVE_MAX));
    assign pred_ready    = !reset && !force_upd;
    // Full means full: a pop on the same edge does not open a slot.
    assign upd_ready     = !reset && (upd_count != CNT_W'(UPD_DEPTH));
    assign push          = upd_valid && upd_ready;
    assign take_pred     = pred_req && !force_upd;
    // Pop on a forced update, or when no predict wants the slot.
    assign pop           = fifo_nonempty && !take_pred;

    // The BHT answers in the cycle after it samples bht_predict.
    assign pred_taken    = bht_prediction;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr]   <= upd_addr;
            fifo_result[wr_ptr] <= upd_result;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            upd_count   <= '0;
            starve_cnt  <= '0;
            bht_addr    <= '0;
            bht_predict <= 1'b0;
            bht_update  <= 1'b0;
            bht_result  <= 1'b0;
            pred_valid  <= 1'b0;
        end else begin
            pred_valid <= (state == ISSUE_PRED);

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            upd_count <= upd_count + CNT_W'(push) - CNT_W'(pop);

            if (pop) begin
                state       <= ISSUE_UPD;
                bht_predict <= 1'b0;
                bht_update  <= 1'b1;
                bht_addr    <= fifo_addr[rd_ptr];
                bht_result  <= fifo_result[rd_ptr];
                starve_cnt  <= '0;
            end else if (take_pred) begin
                state       <= ISSUE_PRED;
                bht_predict <= 1'b1;
                bht_update  <= 1'b0;
                bht_addr    <= pred_addr;
                // Only predicts that overtake a waiting update count as starvation.
                if (fifo_nonempty && (starve_cnt != STV_W'(STARVE_MAX))) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                state       <= IDLE;
                bht_predict <= 1'b0;
                bht_update  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bht_access_scheduler.sv
module tb_bht_access_scheduler;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 4;
    localparam int STARVE = 3;

    logic              clock;
    logic              reset;
    logic              pred_req;
    logic [ADDR_W-1:0] pred_addr;
    logic              pred_ready;
    logic              pred_valid;
    logic              pred_taken;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_addr;
    logic              upd_result;
    logic              upd_ready;
    logic [2:0]        upd_count;
    logic [ADDR_W-1:0] bht_addr;
    logic              bht_predict;
    logic              bht_update;
    logic              bht_result;
    logic              bht_prediction;

    bht_access_scheduler #(
        .ADDR_W(ADDR_W), .UPD_DEPTH(DEPTH), .STARVE_MAX(STARVE)
    ) dut (
        .clock(clock), .reset(reset),
        .pred_req(pred_req), .pred_addr(pred_addr), .pred_ready(pred_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_result(upd_result),
        .upd_ready(upd_ready), .upd_count(upd_count),
        .bht_addr(bht_addr), .bht_predict(bht_predict), .bht_update(bht_update),
        .bht_result(bht_result), .bht_prediction(bht_prediction)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of pending updates plus the issued command.
    logic [ADDR_W-1:0] q_addr[$];
    bit                q_res[$];
    int                starve;
    bit                m_pred, m_upd, m_pv, m_res;
    logic [ADDR_W-1:0] m_addr;
    int                m_acc;

    // Update source: holds an offer until it is accepted.
    logic [ADDR_W-1:0] src_base;
    int                src_next;
    int                src_limit;
    logic [ADDR_W-1:0] issued[$];
    int                n_pv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        q_addr.delete();
        q_res.delete();
        starve = 0;
        m_pred = 0; m_upd = 0; m_pv = 0; m_res = 0;
        m_addr = '0;
    endfunction

    function automatic void model_edge();
        bit ne;
        bit full;
        ne   = (q_addr.size() != 0);
        full = (q_addr.size() == DEPTH);
        m_pv = m_pred;
        if (ne && (starve == STARVE || !pred_req)) begin
            m_pred = 0;
            m_upd  = 1;
            m_addr = q_addr.pop_front();
            m_res  = q_res.pop_front();
            starve = 0;
        end else if (pred_req) begin
            m_pred = 1;
            m_upd  = 0;
            m_addr = pred_addr;
            m_acc++;
            if (ne && starve < STARVE) starve++;
        end else begin
            m_pred = 0;
            m_upd  = 0;
        end
        if (upd_valid && !full) begin
            q_addr.push_back(upd_addr);
            q_res.push_back(upd_result);
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        chk("bht_predict", bht_predict, m_pred);
        chk("bht_update", bht_update, m_upd);
        chk("bht_addr", bht_addr, m_addr);
        chk("bht_result", bht_result, m_res);
        chk("pred_valid", pred_valid, m_pv);
        chk("upd_count", upd_count, q_addr.size());
        chk("pred_ready", pred_ready, !(q_addr.size() != 0 && starve == STARVE));
        chk("upd_ready", upd_ready, q_addr.size() != DEPTH);
        chk("pred_upd_exclusive", bht_predict && bht_update, 0);
        if (pred_valid) chk("pred_taken", pred_taken, bht_prediction);
    endtask

    task automatic cycle(input bit preq, input bit offer);
        bit accepted;
        pred_req       = preq;
        pred_addr      = ADDR_W'($urandom);
        bht_prediction = 1'($urandom);
        if (!upd_valid && offer && src_next < src_limit) begin
            upd_valid  = 1'b1;
            upd_addr   = src_base + ADDR_W'(src_next);
            upd_result = 1'($urandom);
        end
        accepted = upd_valid && upd_ready;
        step();
        if (accepted) begin
            upd_valid = 1'b0;
            src_next++;
        end
        if (bht_update) issued.push_back(bht_addr);
        if (pred_valid) n_pv++;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_bht_predict"}, bht_predict, 0);
        chk({tag, "_bht_update"}, bht_update, 0);
        chk({tag, "_bht_addr"}, bht_addr, 0);
        chk({tag, "_bht_result"}, bht_result, 0);
        chk({tag, "_pred_valid"}, pred_valid, 0);
        chk({tag, "_upd_count"}, upd_count, 0);
        chk({tag, "_pred_ready"}, pred_ready, 0);
        chk({tag, "_upd_ready"}, upd_ready, 0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rel_upd_count", upd_count, 0);
        chk("rel_pred_ready", pred_ready, 1);
        chk("rel_upd_ready", upd_ready, 1);
    endtask

    typedef struct {
        bit                pr;
        logic [ADDR_W-1:0] pa;
        bit                uv;
        logic [ADDR_W-1:0] ua;
        bit                ur;
        bit                e_pred;
        bit                e_upd;
        logic [ADDR_W-1:0] e_addr;
        bit                e_res;
        int                e_cnt;
        bit                e_pv;
        bit                e_prdy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Predict latency, then one update starved by three predicts.
        tbl[0] = '{1, 11'h123, 0, 11'h000, 0, 1, 0, 11'h123, 0, 0, 0, 1};
        tbl[1] = '{0, 11'h000, 1, 11'h040, 1, 0, 0, 11'h123, 0, 1, 1, 1};
        tbl[2] = '{1, 11'h200, 0, 11'h000, 0, 1, 0, 11'h200, 0, 1, 0, 1};
        tbl[3] = '{1, 11'h201, 0, 11'h000, 0, 1, 0, 11'h201, 0, 1, 1, 1};
        tbl[4] = '{1, 11'h202, 0, 11'h000, 0, 1, 0, 11'h202, 0, 1, 1, 0};
        tbl[5] = '{1, 11'h203, 0, 11'h000, 0, 0, 1, 11'h040, 1, 0, 1, 1};
        tbl[6] = '{1, 11'h204, 0, 11'h000, 0, 1, 0, 11'h204, 1, 0, 0, 1};
        tbl[7] = '{0, 11'h000, 0, 11'h000, 0, 0, 0, 11'h204, 1, 0, 1, 1};
        tbl[8] = '{0, 11'h000, 0, 11'h000, 0, 0, 0, 11'h204, 1, 0, 0, 1};

        reset = 1'b1;
        pred_req = 0; pred_addr = '0; upd_valid = 0; upd_addr = '0; upd_result = 0;
        bht_prediction = 0;
        src_base = '0; src_next = 0; src_limit = 0; n_pv = 0; m_acc = 0;
        model_reset();
        @(posedge clock);
        #1;
        check_reset_state("por");
        release_reset();

        // Directed table: predict latency and starvation.
        for (int i = 0; i < 9; i++) begin
            pred_req       = tbl[i].pr;
            pred_addr      = tbl[i].pa;
            upd_valid      = tbl[i].uv;
            upd_addr       = tbl[i].ua;
            upd_result     = tbl[i].ur;
            bht_prediction = 1'($urandom);
            step();
            chk($sformatf("tbl%0d_predict", i), bht_predict, tbl[i].e_pred);
            chk($sformatf("tbl%0d_update", i), bht_update, tbl[i].e_upd);
            chk($sformatf("tbl%0d_addr", i), bht_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_result", i), bht_result, tbl[i].e_res);
            chk($sformatf("tbl%0d_count", i), upd_count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_pred_valid", i), pred_valid, tbl[i].e_pv);
            chk($sformatf("tbl%0d_pred_ready", i), pred_ready, tbl[i].e_prdy);
        end
        upd_valid = 0;

        // Reset in the middle of random traffic.
        src_base = 11'h300; src_next = 0; src_limit = 1 << 30;
        for (int i = 0; i < 40; i++) cycle(1'($urandom), 1'($urandom));
        pred_req = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("mid");
        model_reset();
        pred_req = 0; upd_valid = 0;
        @(posedge clock);
        #1;
        check_reset_state("hold");
        release_reset();

        // Full FIFO under continuous predicts: fifth update is held back.
        for (int i = 0; i < 8; i++) cycle(0, 0);
        issued.delete();
        src_base = 11'h100; src_next = 0; src_limit = 5;
        for (int i = 0; i < 20 && upd_count != 3'd4; i++) cycle(1, 1);
        chk("t4_full_count", upd_count, 4);
        chk("t4_full_upd_ready", upd_ready, 0);
        cycle(1, 1);
        chk("t4_fifth_not_taken", src_next, 4);
        chk("t4_count_after_pop", upd_count, 3);
        for (int i = 0; i < 60 && issued.size() < 5; i++) cycle(1, 1);
        chk("t4_issued_total", issued.size(), 5);
        for (int i = 0; i < 5 && i < issued.size(); i++)
            chk($sformatf("t4_order%0d", i), issued[i], 11'h100 + ADDR_W'(i));

        // Simultaneous enqueue/dequeue and pointer wrap over ten updates.
        for (int i = 0; i < 8; i++) cycle(0, 0);
        issued.delete();
        src_base = '0; src_next = 0; src_limit = 10;
        for (int i = 0; i < 20 && upd_count != 3'd4; i++) cycle(1, 1);
        chk("t5_full_count", upd_count, 4);
        cycle(0, 1);
        chk("t5_pop_only", upd_count, 3);
        cycle(0, 1);
        chk("t5_push_pop", upd_count, 3);
        for (int i = 0; i < 40 && issued.size() < 10; i++) cycle(0, 1);
        chk("t5_issued_total", issued.size(), 10);
        for (int i = 0; i < 10 && i < issued.size(); i++)
            chk($sformatf("t5_order%0d", i), issued[i], ADDR_W'(i));

        // Random traffic: exclusivity and one response per accepted predict.
        for (int i = 0; i < 4; i++) cycle(0, 0);
        m_acc = 0; n_pv = 0;
        src_base = 11'h555; src_next = 0; src_limit = 1 << 30;
        for (int i = 0; i < 10000; i++) cycle($urandom_range(3, 0) != 0, 1'($urandom));
        src_limit = src_next;
        for (int i = 0; i < 12; i++) cycle(0, 0);
        chk("t6_pred_valid_count", n_pv, m_acc);
        chk("t6_drained", upd_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
